// File: rtl/mxu_cmd_sequencer_if.sv
// Command, memory and MXU signal bundle for mxu_cmd_sequencer.
// master = sequencer side, slave = decoder/memory/MXU side.
interface mxu_cmd_sequencer_if #(
  parameter int unsigned NUM_SIZE  = 16,
  parameter int unsigned GRID_SIZE = 2,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 8
);
  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [ADDR_W-1:0]                     cmd_a_addr;
  logic [ADDR_W-1:0]                     cmd_b_addr;
  logic [ADDR_W-1:0]                     cmd_c_addr;
  logic                                  mem_rd_en;
  logic [ADDR_W-1:0]                     mem_rd_addr;
  logic [DATA_W-1:0]                     mem_rd_data;
  logic                                  mem_wr_en;
  logic [ADDR_W-1:0]                     mem_wr_addr;
  logic [DATA_W-1:0]                     mem_wr_data;
  logic                                  mxu_clear;
  logic                                  mxu_ce;
  logic [NUM_SIZE*GRID_SIZE-1:0]         mxu_west;
  logic [NUM_SIZE*GRID_SIZE-1:0]         mxu_north;
  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] mxu_result;

  modport master (
    input  cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, mem_rd_data, mxu_result,
    output cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
           mxu_clear, mxu_ce, mxu_west, mxu_north
  );

  modport slave (
    output cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, mem_rd_data, mxu_result,
    input  cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
           mxu_clear, mxu_ce, mxu_west, mxu_north
  );
endinterface

// File: rtl/mxu_cmd_sequencer.sv
// Matmul command sequencer: loads A/B from byte memory, streams skewed operands
// into the systolic MXU, then writes the truncated C matrix back row-major.
module mxu_cmd_sequencer #(
  parameter int unsigned NUM_SIZE  = 16,
  parameter int unsigned GRID_SIZE = 2,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  mxu_cmd_sequencer_if.master bus,
  output logic                busy,
  output logic                done
);
  localparam int unsigned GG       = GRID_SIZE * GRID_SIZE;
  localparam int unsigned LOAD_CYC = 2 * GG + 1;
  localparam int unsigned COMP_CYC = 3 * GRID_SIZE - 2;
  localparam int unsigned CNT_W    = $clog2(LOAD_CYC);
  localparam int unsigned IDX_W    = (GG > 1) ? $clog2(GG) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  int unsigned       cnt_u;
  logic [ADDR_W-1:0] a_q, b_q, c_q;
  logic [DATA_W-1:0] a_reg [GG];
  logic [DATA_W-1:0] b_reg [GG];

  assign cnt_u = 32'(cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else if (state == IDLE && bus.cmd_valid) begin
      a_q <= bus.cmd_a_addr;
      b_q <= bus.cmd_b_addr;
      c_q <= bus.cmd_c_addr;
    end
  end

  // Read data lags its strobe by one cycle, so LOAD step n captures word n-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '{default: '0};
      b_reg <= '{default: '0};
    end else if (state == LOAD && cnt_u != 0) begin
      if (cnt_u <= GG) a_reg[IDX_W'(cnt_u - 1)]      <= bus.mem_rd_data;
      else             b_reg[IDX_W'(cnt_u - 1 - GG)] <= bus.mem_rd_data;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.cmd_valid)           state_next = LOAD;
      LOAD:    if (cnt_u == LOAD_CYC - 1)   state_next = COMPUTE;
      COMPUTE: if (cnt_u == COMP_CYC - 1)   state_next = WRITE;
      WRITE:   if (cnt_u == GG - 1)         state_next = DONE;
      DONE:                                 state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready   = (state == IDLE);
    busy            = (state != IDLE);
    done            = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mxu_clear   = 1'b0;
    bus.mxu_ce      = 1'b0;
    bus.mxu_west    = '0;
    bus.mxu_north   = '0;
    unique case (state)
      LOAD: begin
        bus.mxu_clear = (cnt_u == 0);
        if (cnt_u < 2 * GG) begin
          bus.mem_rd_en   = 1'b1;
          bus.mem_rd_addr = (cnt_u < GG) ? a_q + ADDR_W'(cnt_u) : b_q + ADDR_W'(cnt_u - GG);
        end
      end
      COMPUTE: begin
        bus.mxu_ce = 1'b1;
        // Row i / column i enters i steps late, giving the diagonal wavefront.
        for (int unsigned i = 0; i < GRID_SIZE; i++) begin
          if (cnt_u >= i && cnt_u - i < GRID_SIZE) begin
            bus.mxu_west[i*NUM_SIZE +: NUM_SIZE] =
              NUM_SIZE'(a_reg[IDX_W'(i * GRID_SIZE + cnt_u - i)]);
            bus.mxu_north[i*NUM_SIZE +: NUM_SIZE] =
              NUM_SIZE'(b_reg[IDX_W'((cnt_u - i) * GRID_SIZE + i)]);
          end
        end
      end
      WRITE: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = c_q + ADDR_W'(cnt_u);
        bus.mem_wr_data = bus.mxu_result[NUM_SIZE*cnt_u +: DATA_W];
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mxu_cmd_sequencer.sv
// Bench for mxu_cmd_sequencer: byte memory and 2x2 systolic MXU models around the
// DUT, with a plain matrix-product reference kept in a shadow memory.
module tb_mxu_cmd_sequencer;
  localparam int unsigned NUM_SIZE = 16;
  localparam int unsigned G        = 2;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy, done;

  mxu_cmd_sequencer_if #(.NUM_SIZE(NUM_SIZE), .GRID_SIZE(G), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mxu_cmd_sequencer #(.NUM_SIZE(NUM_SIZE), .GRID_SIZE(G), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Byte memory: registered read, write port for the DUT, load port for the bench.
  logic [7:0]  mem [32];
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  int unsigned wr_count = 0;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    if (bus.mem_wr_en) begin
      mem[bus.mem_wr_addr] <= bus.mem_wr_data;
      wr_count <= wr_count + 1;
    end
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Output-stationary systolic array: operands hop one PE per enabled cycle.
  logic [15:0] acc [2][2];
  logic [15:0] wreg [2][2];
  logic [15:0] nreg [2][2];
  logic [15:0] w_in, n_in;

  always @(posedge clk) begin
    if (bus.mxu_clear) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          acc[i][j] <= '0; wreg[i][j] <= '0; nreg[i][j] <= '0;
        end
    end else if (bus.mxu_ce) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          if (j == 0) w_in = bus.mxu_west[i*16 +: 16];
          else        w_in = wreg[i][j-1];
          if (i == 0) n_in = bus.mxu_north[j*16 +: 16];
          else        n_in = nreg[i-1][j];
          acc[i][j]  <= acc[i][j] + w_in * n_in;
          wreg[i][j] <= w_in;
          nreg[i][j] <= n_in;
        end
    end
  end

  always_comb begin
    bus.mxu_result = '0;
    for (int k = 0; k < 4; k++) bus.mxu_result[k*16 +: 16] = acc[k/2][k%2];
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [32];

  logic        rec_ready [64], rec_done [64], rec_busy [64], rec_clear [64];
  logic        rec_rd_en [64], rec_wr_en [64], rec_ce [64];
  logic [4:0]  rec_rd_addr [64], rec_wr_addr [64];
  logic [31:0] rec_west [64], rec_north [64];

  task automatic poke(input int addr, input logic [7:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 5'(addr); ld_data = val;
    ref_mem[addr] = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic sample(input int n);
    rec_ready[n] = bus.cmd_ready;  rec_done[n]  = done;       rec_busy[n] = busy;
    rec_clear[n] = bus.mxu_clear;  rec_rd_en[n] = bus.mem_rd_en;
    rec_wr_en[n] = bus.mem_wr_en;  rec_ce[n]    = bus.mxu_ce;
    rec_rd_addr[n] = bus.mem_rd_addr; rec_wr_addr[n] = bus.mem_wr_addr;
    rec_west[n] = bus.mxu_west;    rec_north[n] = bus.mxu_north;
  endtask

  // Offers one command at cycle 0 and records ncyc cycles (DUT must be idle).
  task automatic run_cmd(input logic [4:0] a, b, c, input int ncyc);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_a_addr = a; bus.cmd_b_addr = b; bus.cmd_c_addr = c;
    sample(0);
    for (int n = 1; n < ncyc; n++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      sample(n);
    end
  endtask

  // Reference: C = A*B from the shadow memory, low byte written back row-major.
  task automatic model_cmd(input logic [4:0] a, b, c);
    int av [4];
    int bv [4];
    int cv [4];
    for (int k = 0; k < 4; k++) begin
      av[k] = int'(ref_mem[(int'(a) + k) % 32]);
      bv[k] = int'(ref_mem[(int'(b) + k) % 32]);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        cv[i*2+j] = (av[i*2] * bv[j] + av[i*2+1] * bv[2+j]) % 256;
    for (int k = 0; k < 4; k++) ref_mem[(int'(c) + k) % 32] = 8'(cv[k]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a_addr = '0; bus.cmd_b_addr = '0; bus.cmd_c_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", bus.cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.mxu_ce, bus.mxu_clear} !== 4'b0)
      begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {bus.mem_rd_en, bus.mem_wr_en, bus.mxu_ce, bus.mxu_clear}); end
    checks++; if ({bus.mxu_west, bus.mxu_north} !== 64'h0)
      begin errors++; $display("FAIL reset_operands got=%h exp=0", {bus.mxu_west, bus.mxu_north}); end
    rst = 1'b0;
    for (int k = 0; k < 32; k++) poke(k, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_identity;
    logic [7:0] init [8] = '{1, 2, 3, 4, 1, 0, 0, 1};
    logic [4:0] ea;
    for (int k = 0; k < 8; k++) poke(k, init[k]);
    model_cmd(5'd0, 5'd4, 5'd8);
    run_cmd(5'd0, 5'd4, 5'd8, 30);
    for (int n = 0; n < 30; n++) begin
      checks++; if (rec_done[n] !== (n == 18)) begin errors++; $display("FAIL tl_done cyc=%0d got=%0b exp=%0b", n, rec_done[n], n == 18); end
      checks++; if (rec_ready[n] !== (n == 0 || n >= 19)) begin errors++; $display("FAIL tl_ready cyc=%0d got=%0b exp=%0b", n, rec_ready[n], n == 0 || n >= 19); end
      checks++; if (rec_busy[n] !== (n >= 1 && n <= 18)) begin errors++; $display("FAIL tl_busy cyc=%0d got=%0b exp=%0b", n, rec_busy[n], n >= 1 && n <= 18); end
      checks++; if (rec_clear[n] !== (n == 1)) begin errors++; $display("FAIL tl_clear cyc=%0d got=%0b exp=%0b", n, rec_clear[n], n == 1); end
      checks++; if (rec_ce[n] !== (n >= 10 && n <= 13)) begin errors++; $display("FAIL tl_ce cyc=%0d got=%0b exp=%0b", n, rec_ce[n], n >= 10 && n <= 13); end
      checks++; if (rec_rd_en[n] !== (n >= 1 && n <= 8)) begin errors++; $display("FAIL tl_rd_en cyc=%0d got=%0b exp=%0b", n, rec_rd_en[n], n >= 1 && n <= 8); end
      checks++; if (rec_wr_en[n] !== (n >= 14 && n <= 17)) begin errors++; $display("FAIL tl_wr_en cyc=%0d got=%0b exp=%0b", n, rec_wr_en[n], n >= 14 && n <= 17); end
      if (n >= 1 && n <= 8) begin
        ea = 5'(n - 1);
        checks++; if (rec_rd_addr[n] !== ea) begin errors++; $display("FAIL tl_rd_addr cyc=%0d got=%0d exp=%0d", n, rec_rd_addr[n], ea); end
      end
      if (n >= 14 && n <= 17) begin
        ea = 5'(8 + n - 14);
        checks++; if (rec_wr_addr[n] !== ea) begin errors++; $display("FAIL tl_wr_addr cyc=%0d got=%0d exp=%0d", n, rec_wr_addr[n], ea); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem[8+k] !== 8'(k + 1)) begin errors++; $display("FAIL identity_c%0d got=%0d exp=%0d", k, mem[8+k], k + 1); end
    end
    for (int k = 0; k < 32; k++) begin
      checks++; if (mem[k] !== ref_mem[k]) begin errors++; $display("FAIL identity_mem[%0d] got=%0h exp=%0h", k, mem[k], ref_mem[k]); end
    end
  endtask

  task automatic test_product;
    logic [7:0] init [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    logic [7:0] cexp [4] = '{19, 22, 43, 50};
    logic [31:0] ew, en;
    int t;
    for (int k = 0; k < 8; k++) poke(k, init[k]);
    model_cmd(5'd0, 5'd4, 5'd8);
    run_cmd(5'd0, 5'd4, 5'd8, 20);
    for (int n = 0; n < 20; n++) begin
      ew = '0; en = '0;
      t = n - 10;
      if (n >= 10 && n <= 13)
        for (int i = 0; i < 2; i++)
          if (t - i >= 0 && t - i < 2) begin
            ew[i*16 +: 16] = 16'(init[i*2 + t - i]);
            en[i*16 +: 16] = 16'(init[4 + (t - i)*2 + i]);
          end
      checks++; if (rec_west[n] !== ew) begin errors++; $display("FAIL west cyc=%0d got=%h exp=%h", n, rec_west[n], ew); end
      checks++; if (rec_north[n] !== en) begin errors++; $display("FAIL north cyc=%0d got=%h exp=%h", n, rec_north[n], en); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem[8+k] !== cexp[k]) begin errors++; $display("FAIL product_c%0d got=%0d exp=%0d", k, mem[8+k], cexp[k]); end
    end
  endtask

  task automatic test_truncation;
    for (int k = 0; k < 4; k++) begin poke(12 + k, 8'd16); poke(20 + k, 8'd16); poke(24 + k, 8'hFF); end
    model_cmd(5'd12, 5'd20, 5'd24);
    run_cmd(5'd12, 5'd20, 5'd24, 20);
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem[24+k] !== 8'h00) begin errors++; $display("FAIL trunc_c%0d got=%0h exp=00", k, mem[24+k]); end
    end
  endtask

  task automatic test_wrap;
    logic [4:0] ea [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
    for (int k = 0; k < 4; k++) poke(int'(ea[k]), 8'($urandom_range(0, 255)));
    model_cmd(5'd30, 5'd4, 5'd8);
    run_cmd(5'd30, 5'd4, 5'd8, 20);
    for (int n = 1; n <= 4; n++) begin
      checks++; if (rec_rd_en[n] !== 1'b1 || rec_rd_addr[n] !== ea[n-1])
        begin errors++; $display("FAIL wrap_rd cyc=%0d got=%0b/%0d exp=1/%0d", n, rec_rd_en[n], rec_rd_addr[n], ea[n-1]); end
    end
    for (int k = 0; k < 32; k++) begin
      checks++; if (mem[k] !== ref_mem[k]) begin errors++; $display("FAIL wrap_mem[%0d] got=%0h exp=%0h", k, mem[k], ref_mem[k]); end
    end
  endtask

  task automatic test_random;
    logic [4:0] a, b, c;
    int dcyc;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 4; k++) poke($urandom_range(0, 31), 8'($urandom_range(0, 255)));
      a = 5'($urandom_range(0, 31)); b = 5'($urandom_range(0, 31)); c = 5'($urandom_range(0, 31));
      model_cmd(a, b, c);
      run_cmd(a, b, c, 30);
      dcyc = -1;
      for (int n = 29; n >= 0; n--) if (rec_done[n] === 1'b1) dcyc = n;
      checks++; if (dcyc != 18) begin errors++; $display("FAIL rand_done it=%0d got=%0d exp=18", it, dcyc); end
      for (int k = 0; k < 32; k++) begin
        checks++; if (mem[k] !== ref_mem[k]) begin errors++; $display("FAIL rand_mem it=%0d [%0d] got=%0h exp=%0h", it, k, mem[k], ref_mem[k]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 8; k++) poke(k, 8'($urandom_range(0, 255)));
    model_cmd(5'd0, 5'd4, 5'd8);
    model_cmd(5'd8, 5'd4, 5'd12);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_a_addr = 5'd0; bus.cmd_b_addr = 5'd4; bus.cmd_c_addr = 5'd8;
    sample(0);
    for (int n = 1; n < 40; n++) begin
      @(negedge clk);
      if (n == 1) begin bus.cmd_a_addr = 5'd8; bus.cmd_c_addr = 5'd12; end
      if (n == 20) bus.cmd_valid = 1'b0;
      sample(n);
    end
    for (int n = 0; n < 40; n++) begin
      checks++; if (rec_ready[n] !== (n == 0 || n == 19 || n >= 38))
        begin errors++; $display("FAIL b2b_ready cyc=%0d got=%0b exp=%0b", n, rec_ready[n], n == 0 || n == 19 || n >= 38); end
      checks++; if (rec_done[n] !== (n == 18 || n == 37))
        begin errors++; $display("FAIL b2b_done cyc=%0d got=%0b exp=%0b", n, rec_done[n], n == 18 || n == 37); end
    end
    for (int k = 0; k < 32; k++) begin
      checks++; if (mem[k] !== ref_mem[k]) begin errors++; $display("FAIL b2b_mem[%0d] got=%0h exp=%0h", k, mem[k], ref_mem[k]); end
    end
  endtask

  task automatic test_reset_mid;
    int unsigned wc;
    for (int k = 0; k < 4; k++) poke(16 + k, 8'hA5);
    wc = wr_count;
    run_cmd(5'd0, 5'd4, 5'd16, 13);
    rst = 1'b1;
    #1;
    checks++; if (bus.mxu_ce !== 1'b0) begin errors++; $display("FAIL rstmid_ce got=%0b exp=0", bus.mxu_ce); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got=%0b exp=0", bus.mem_wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got=%0b exp=0", bus.mem_rd_en); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%0b exp=1", bus.cmd_ready); end
    checks++; if (wr_count !== wc) begin errors++; $display("FAIL rstmid_writes got=%0d exp=%0d", wr_count, wc); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem[16+k] !== 8'hA5) begin errors++; $display("FAIL rstmid_c%0d got=%0h exp=a5", k, mem[16+k]); end
    end
    model_cmd(5'd0, 5'd4, 5'd16);
    run_cmd(5'd0, 5'd4, 5'd16, 20);
    for (int k = 0; k < 32; k++) begin
      checks++; if (mem[k] !== ref_mem[k]) begin errors++; $display("FAIL rstmid_after[%0d] got=%0h exp=%0h", k, mem[k], ref_mem[k]); end
    end
  endtask

  initial begin
    test_reset;
    test_identity;
    test_product;
    test_truncation;
    test_wrap;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
